logic_axi4_stream_mux_unit: RTL and testbench
=============================================

Name: logic_axi4_stream_mux_unit

Overview:
- N-to-1 AXI4-Stream multiplexer: merges INPUTS rx streams into one registered tx stream.
- Round-robin arbitration with packet locking, so a granted input keeps the output until its tlast beat is accepted.
- Counterpart of the stream demultiplexer: it recombines demultiplexed or independent streams toward a shared sink.
- tdest/tid are passed through unmodified.

Parameters:
INPUTS, 2, number of rx inputs (>=1)
TDATA_BYTES, 1, tdata width in bytes (0 disables tdata/tkeep/tstrb)
TDEST_WIDTH, 1, tdest width (0 disables)
TUSER_WIDTH, 1, tuser width (0 disables)
TID_WIDTH, 1, tid width (0 disables)
USE_TKEEP, 1, forward tkeep; when 0, tx.tkeep is driven all-ones
USE_TSTRB, 1, forward tstrb; when 0, tx.tstrb is driven all-ones
USE_TLAST, 1, forward tlast and lock per packet; when 0, tx.tlast is driven 1 and arbitration is per beat

Ports:
aclk  input  1  clock; all logic on the rising edge
areset_n  input  1  asynchronous active-low reset
rx[INPUTS]  logic_axi4_stream_if rx modport  params  input streams (tvalid, tready, tdata, tkeep, tstrb, tlast, tuser, tdest, tid)
tx  logic_axi4_stream_if tx modport  params  merged output stream

Behaviour:
- Reset: tx.tvalid=0, state=IDLE, round-robin pointer=0, lock index=0. Data fields of tx are don't-care (not reset).
- Load enable: load = tx.tready || !tx.tvalid. This is a registered stage that fills bubbles.
- Grant (combinational, one-hot, at most one bit):
  - IDLE: the first input with rx[i].tvalid=1, searching from pointer upward with wrap-around (pointer, pointer+1, ..., INPUTS-1, 0, ...).
  - LOCKED: only the locked index is granted, regardless of whether its tvalid is high.
- rx[i].tready = load && grant[i]. Non-granted inputs see tready=0. tready never depends combinationally on tx.tvalid of another input.
- Accept on input g = rx[g].tvalid && rx[g].tready. Latency is 1 cycle.
- On accept, tx registers load the rx[g] fields. Disabled fields use the constants listed under Parameters.
- tx.tvalid update when load=1: tx.tvalid <= (accept occurred). When load=0, tx.tvalid and all data hold stable (AXI rule).
- FSM IDLE -> LOCKED: on accept with tlast=0 and USE_TLAST=1. Lock index = g.
- FSM LOCKED -> IDLE: on accept from the locked input with tlast=1.
- Pointer update: after every packet-ending accept (tlast=1, or any accept when USE_TLAST=0), pointer <= (g+1) mod INPUTS.
- LOCKED with the locked input's tvalid=0: no transfer (bubble on tx). Other inputs stay blocked.
- INPUTS=1: the pointer is a constant 0 and the block degenerates to a registered slice with lock logic.
- Reset asserted mid-packet: the block returns to IDLE with pointer=0 and tx.tvalid=0 immediately (asynchronous). The partial packet is dropped and not resumed.
- Simultaneous valids in IDLE: exactly one grant, chosen by pointer order. Others wait with tready=0.

Test Plan:
- Single input: rx[0] sends 3-beat packet A0,A1,A2 (tlast on A2), tx.tready=1 -> tx shows A0,A1,A2 on consecutive cycles, each 1 cycle after its accept; tlast only on A2.
- Fairness, INPUTS=2: both inputs continuously present single-beat packets (tlast=1), values 0x10.. on rx[0] and 0x20.. on rx[1] -> tx sequence 0x10,0x20,0x11,0x21; each input's tready is high on alternate cycles.
- Packet lock: rx[0] 4-beat packet, rx[1] valid from cycle 1 -> rx[1].tready stays 0 until rx[0]'s tlast beat is accepted; rx[1]'s beat appears on tx immediately after rx[0]'s tlast beat, with no interleaving.
- Backpressure: tx.tready=0 for 5 cycles while tx.tvalid=1 with tdata=0x5A -> tx.tdata/tlast/tdest/tid hold 0x5A and the other fields unchanged; all rx tready=0; resuming tx.tready=1 continues with no loss or duplication.
- Bubble in locked packet: rx[0] deasserts tvalid mid-packet for 2 cycles while rx[1] is valid -> tx.tvalid=0 for those cycles, rx[1].tready=0, and the packet resumes on rx[0].
- USE_TLAST=0: two inputs both valid with multi-beat streams -> strict per-beat alternation, tx.tlast=1 on every beat.
- Reset mid-packet: assert areset_n=0 during beat 2 of a 4-beat rx[1] packet -> tx.tvalid=0 the same cycle; after release, rx[0] and rx[1] both valid -> rx[0] is granted first (pointer=0).

Source files
------------

// File: rtl/logic_axi4_stream_mux_unit_if.sv
// AXI4-Stream channel bundle shared by the stream mux and its neighbours.
// Disabled fields collapse to a 1-bit signal so every port stays legal.
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  localparam int DW  = (TDATA_BYTES > 0) ? TDATA_BYTES * 8 : 1;
  localparam int KW  = (TDATA_BYTES > 0) ? TDATA_BYTES : 1;
  localparam int UW  = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
  localparam int DSW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
  localparam int IW  = (TID_WIDTH > 0) ? TID_WIDTH : 1;

  logic           tvalid;
  logic           tready;
  logic [DW-1:0]  tdata;
  logic [KW-1:0]  tkeep;
  logic [KW-1:0]  tstrb;
  logic           tlast;
  logic [UW-1:0]  tuser;
  logic [DSW-1:0] tdest;
  logic [IW-1:0]  tid;

  modport tx (
    output tvalid,
    output tdata,
    output tkeep,
    output tstrb,
    output tlast,
    output tuser,
    output tdest,
    output tid,
    input  tready
  );

  modport rx (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tstrb,
    input  tlast,
    input  tuser,
    input  tdest,
    input  tid,
    output tready
  );
endinterface

// File: rtl/logic_axi4_stream_mux_unit.sv
// N-to-1 AXI4-Stream mux: round-robin grant, packet locking,
// single registered output slice that fills bubbles.
module logic_axi4_stream_mux_unit #(
  parameter int INPUTS      = 2,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter bit USE_TKEEP   = 1'b1,
  parameter bit USE_TSTRB   = 1'b1,
  parameter bit USE_TLAST   = 1'b1
) (
  input  logic            aclk,
  input  logic            areset_n,
  logic_axi4_stream_if.rx rx [INPUTS],
  logic_axi4_stream_if.tx tx
);
  localparam int DW  = (TDATA_BYTES > 0) ? TDATA_BYTES * 8 : 1;
  localparam int KW  = (TDATA_BYTES > 0) ? TDATA_BYTES : 1;
  localparam int UW  = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
  localparam int DSW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
  localparam int IW  = (TID_WIDTH > 0) ? TID_WIDTH : 1;
  localparam int PW  = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  lock_q, lock_d;
  logic           tvalid_q, tvalid_d;
  logic [DW-1:0]  data_q, data_d;
  logic [KW-1:0]  keep_q, keep_d;
  logic [KW-1:0]  strb_q, strb_d;
  logic           last_q, last_d;
  logic [UW-1:0]  user_q, user_d;
  logic [DSW-1:0] dest_q, dest_d;
  logic [IW-1:0]  id_q, id_d;

  logic [INPUTS-1:0] rx_valid;
  logic [INPUTS-1:0] rx_last;
  logic [INPUTS-1:0] rx_ready;
  logic [DW-1:0]     rx_data [INPUTS];
  logic [KW-1:0]     rx_keep [INPUTS];
  logic [KW-1:0]     rx_strb [INPUTS];
  logic [UW-1:0]     rx_user [INPUTS];
  logic [DSW-1:0]    rx_dest [INPUTS];
  logic [IW-1:0]     rx_id   [INPUTS];

  logic [INPUTS-1:0] grant;
  logic [PW-1:0]     gidx;
  logic              found;
  logic              load;
  logic              accept;
  logic              sel_last;

  for (genvar i = 0; i < INPUTS; i++) begin : g_rx
    assign rx_valid[i]  = rx[i].tvalid;
    assign rx_last[i]   = rx[i].tlast;
    assign rx_data[i]   = rx[i].tdata;
    assign rx_keep[i]   = rx[i].tkeep;
    assign rx_strb[i]   = rx[i].tstrb;
    assign rx_user[i]   = rx[i].tuser;
    assign rx_dest[i]   = rx[i].tdest;
    assign rx_id[i]     = rx[i].tid;
    assign rx[i].tready = rx_ready[i];
  end

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % INPUTS);
  endfunction

  // Locked packets own the output even while their source idles.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    if (state_q == LOCKED) begin
      found = 1'b1;
      gidx  = lock_q;
    end else begin
      for (int k = 0; k < INPUTS; k++) begin
        if (!found && rx_valid[wrap(int'(ptr_q) + k)]) begin
          found = 1'b1;
          gidx  = wrap(int'(ptr_q) + k);
        end
      end
    end
    grant[gidx] = found;
  end

  assign load     = tx.tready || !tvalid_q;
  assign rx_ready = load ? grant : '0;
  assign accept   = found && rx_valid[gidx] && load;
  assign sel_last = USE_TLAST ? rx_last[gidx] : 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    lock_d   = lock_q;
    tvalid_d = tvalid_q;
    data_d   = data_q;
    keep_d   = keep_q;
    strb_d   = strb_q;
    last_d   = last_q;
    user_d   = user_q;
    dest_d   = dest_q;
    id_d     = id_q;
    if (load) begin
      tvalid_d = accept;
    end
    if (accept) begin
      data_d = rx_data[gidx];
      keep_d = rx_keep[gidx];
      strb_d = rx_strb[gidx];
      last_d = sel_last;
      user_d = rx_user[gidx];
      dest_d = rx_dest[gidx];
      id_d   = rx_id[gidx];
      if (sel_last) begin
        state_d = IDLE;
        ptr_d   = wrap(int'(gidx) + 1);
      end else begin
        state_d = LOCKED;
        lock_d  = gidx;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      lock_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Payload is qualified by tvalid, so it carries no reset.
  always_ff @(posedge aclk) begin
    data_q <= data_d;
    keep_q <= keep_d;
    strb_q <= strb_d;
    last_q <= last_d;
    user_q <= user_d;
    dest_q <= dest_d;
    id_q   <= id_d;
  end

  assign tx.tvalid = tvalid_q;
  assign tx.tdata  = (TDATA_BYTES > 0) ? data_q : '0;
  assign tx.tkeep  = (TDATA_BYTES > 0 && USE_TKEEP) ? keep_q : '1;
  assign tx.tstrb  = (TDATA_BYTES > 0 && USE_TSTRB) ? strb_q : '1;
  assign tx.tlast  = USE_TLAST ? last_q : 1'b1;
  assign tx.tuser  = (TUSER_WIDTH > 0) ? user_q : '0;
  assign tx.tdest  = (TDEST_WIDTH > 0) ? dest_q : '0;
  assign tx.tid    = (TID_WIDTH > 0) ? id_q : '0;

endmodule

// File: tb/tb_logic_axi4_stream_mux_unit.sv
// Bench for the stream mux: two instances (packet lock on / off),
// queue-fed sources, a per-cycle reference model and directed sequences.
module tb_logic_axi4_stream_mux_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       rv [2][2];
  logic [7:0] rd [2][2];
  logic       rl [2][2];
  logic       rr [2][2];
  logic       adv [2][2];
  logic       tv [2];
  logic       tr [2];
  logic [13:0] tbt [2];

  int         sq [2][2][$];
  logic [7:0] oq [2][$];

  logic        m_valid [2];
  logic [13:0] m_beat [2];
  int          m_ptr [2];
  int          m_own [2];

  logic_axi4_stream_if rxa [2] ();
  logic_axi4_stream_if rxb [2] ();
  logic_axi4_stream_if txa ();
  logic_axi4_stream_if txb ();

  for (genvar i = 0; i < 2; i++) begin : g_c
    assign rxa[i].tvalid = rv[0][i];
    assign rxa[i].tdata  = rd[0][i];
    assign rxa[i].tkeep  = rd[0][i][0];
    assign rxa[i].tstrb  = rd[0][i][1];
    assign rxa[i].tlast  = rl[0][i];
    assign rxa[i].tuser  = rd[0][i][2];
    assign rxa[i].tdest  = rd[0][i][3];
    assign rxa[i].tid    = rd[0][i][4];
    assign rr[0][i]      = rxa[i].tready;
    assign rxb[i].tvalid = rv[1][i];
    assign rxb[i].tdata  = rd[1][i];
    assign rxb[i].tkeep  = rd[1][i][0];
    assign rxb[i].tstrb  = rd[1][i][1];
    assign rxb[i].tlast  = rl[1][i];
    assign rxb[i].tuser  = rd[1][i][2];
    assign rxb[i].tdest  = rd[1][i][3];
    assign rxb[i].tid    = rd[1][i][4];
    assign rr[1][i]      = rxb[i].tready;
  end

  assign tv[0] = txa.tvalid;
  assign tv[1] = txb.tvalid;
  assign txa.tready = tr[0];
  assign txb.tready = tr[1];
  assign tbt[0] = {txa.tdata, txa.tkeep, txa.tstrb, txa.tlast,
                   txa.tuser, txa.tdest, txa.tid};
  assign tbt[1] = {txb.tdata, txb.tkeep, txb.tstrb, txb.tlast,
                   txb.tuser, txb.tdest, txb.tid};

  logic_axi4_stream_mux_unit #(
    .INPUTS(2), .USE_TLAST(1'b1)
  ) dut0 (
    .aclk(clk), .areset_n(rst_n), .rx(rxa), .tx(txa)
  );

  logic_axi4_stream_mux_unit #(
    .INPUTS(2), .USE_TLAST(1'b0)
  ) dut1 (
    .aclk(clk), .areset_n(rst_n), .rx(rxb), .tx(txb)
  );

  task automatic check(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // Reference: one output register, round-robin owner/pointer per instance.
  always @(negedge clk) begin : cmp
    int g;
    int idx;
    logic ld;
    logic acc;
    logic lst;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        check("reset_tvalid", 64'(tv[d]), 64'(0));
        m_valid[d] = 1'b0;
        m_own[d] = -1;
        m_ptr[d] = 0;
      end else begin
        check("tvalid", 64'(tv[d]), 64'(m_valid[d]));
        if (m_valid[d]) check("beat", 64'(tbt[d]), 64'(m_beat[d]));
        ld = tr[d] || !m_valid[d];
        g = m_own[d];
        if (g < 0) begin
          for (int k = 0; k < 2; k++) begin
            idx = (m_ptr[d] + k) % 2;
            if (g < 0 && rv[d][idx]) g = idx;
          end
        end
        for (int i = 0; i < 2; i++)
          check("tready", 64'(rr[d][i]), 64'(ld && g == i));
        if (m_valid[d] && tr[d]) oq[d].push_back(m_beat[d][13:6]);
        acc = 1'b0;
        if (g >= 0) acc = ld && rv[d][g];
        if (ld) m_valid[d] = acc;
        if (acc) begin
          lst = (d == 0) ? rl[d][g] : 1'b1;
          m_beat[d] = {rd[d][g], rd[d][g][0], rd[d][g][1], lst,
                       rd[d][g][2], rd[d][g][3], rd[d][g][4]};
          adv[d][g] = 1'b1;
          if (lst) begin
            m_own[d] = -1;
            m_ptr[d] = (g + 1) % 2;
          end else begin
            m_own[d] = g;
          end
        end
      end
    end
  end

  // Sources: queue entry = gap<<16 | last<<8 | data.
  always @(posedge clk) begin : drv
    int e;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          rv[d][i] = 1'b0;
          adv[d][i] = 1'b0;
        end else begin
          if (adv[d][i]) begin
            adv[d][i] = 1'b0;
            if (sq[d][i].size() > 0) void'(sq[d][i].pop_front());
          end
          rv[d][i] = 1'b0;
          if (sq[d][i].size() > 0) begin
            e = sq[d][i][0];
            if (e >= 65536) begin
              sq[d][i][0] = e - 65536;
            end else begin
              rv[d][i] = 1'b1;
              rd[d][i] = e[7:0];
              rl[d][i] = e[8];
            end
          end
        end
      end
    end
  end

  task automatic push(input int d, input int i, input int data,
                      input int last, input int gap);
    sq[d][i].push_back((gap << 16) | (last << 8) | data);
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      oq[d].delete();
      for (int i = 0; i < 2; i++) sq[d][i].delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_all();
    tr[0] = 1'b1;
    tr[1] = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    clear_all();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int d);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (sq[d][0].size() == 0 && sq[d][1].size() == 0 && !tv[d]) break;
    end
    check("idle_timeout", 64'(n >= 300), 64'(0));
  endtask

  task automatic check_seq(input string nm, input int d, input int n,
                           input logic [63:0] e);
    logic [63:0] a;
    a = '0;
    for (int k = 0; k < oq[d].size(); k++) a = (a << 8) | 64'(oq[d][k]);
    check({nm, "_len"}, 64'(oq[d].size()), 64'(n));
    check(nm, a, e);
    oq[d].delete();
  endtask

  initial begin : main
    int n;
    rst_n = 1'b1;
    tr[0] = 1'b1;
    tr[1] = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2; i++) begin
        rv[d][i] = 1'b0;
        adv[d][i] = 1'b0;
      end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_tvalid_lit", 64'(tv[0]), 64'(0));
    rst_n = 1'b1;

    push(0, 0, 'hA0, 0, 0);
    push(0, 0, 'hA1, 0, 0);
    push(0, 0, 'hA2, 1, 0);
    wait_idle(0);
    check_seq("single", 0, 3, 64'hA0A1A2);

    do_reset();
    push(0, 0, 'h10, 1, 0);
    push(0, 0, 'h11, 1, 0);
    push(0, 1, 'h20, 1, 0);
    push(0, 1, 'h21, 1, 0);
    wait_idle(0);
    check_seq("fair", 0, 4, 64'h10201121);

    do_reset();
    push(0, 0, 'h30, 0, 0);
    push(0, 0, 'h31, 0, 0);
    push(0, 0, 'h32, 0, 0);
    push(0, 0, 'h33, 1, 0);
    push(0, 1, 'h40, 1, 1);
    wait_idle(0);
    check_seq("lock", 0, 5, 64'h3031323340);

    do_reset();
    tr[0] = 1'b0;
    push(0, 0, 'h5A, 1, 0);
    push(0, 0, 'h5B, 1, 0);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tv[0]) break;
    end
    check("bp_valid_seen", 64'(tv[0]), 64'(1));
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_hold_data", 64'(tbt[0][13:6]), 64'h5A);
      check("bp_hold_last", 64'(txa.tlast), 64'(1));
    end
    @(posedge clk);
    #2 tr[0] = 1'b1;
    wait_idle(0);
    check_seq("bp", 0, 2, 64'h5A5B);

    do_reset();
    push(0, 0, 'h60, 0, 0);
    push(0, 0, 'h61, 0, 0);
    push(0, 0, 'h62, 0, 2);
    push(0, 0, 'h63, 1, 0);
    push(0, 1, 'h70, 1, 0);
    wait_idle(0);
    check_seq("bubble", 0, 5, 64'h6061626370);

    do_reset();
    push(1, 0, 'h80, 0, 0);
    push(1, 0, 'h81, 0, 0);
    push(1, 0, 'h82, 1, 0);
    push(1, 1, 'h90, 0, 0);
    push(1, 1, 'h91, 0, 0);
    push(1, 1, 'h92, 1, 0);
    wait_idle(1);
    check_seq("nolast", 1, 6, 64'h809081918292);

    do_reset();
    push(0, 1, 'hB0, 0, 0);
    push(0, 1, 'hB1, 0, 0);
    push(0, 1, 'hB2, 0, 0);
    push(0, 1, 'hB3, 1, 0);
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (tv[0] && tbt[0][13:6] == 8'hB1) break;
    end
    check("rst_b1_seen", 64'(n < 30), 64'(1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    clear_all();
    #1;
    check("rst_async_tvalid", 64'(tv[0]), 64'(0));
    repeat (2) @(posedge clk);
    #3;
    clear_all();
    rst_n = 1'b1;
    push(0, 0, 'hC0, 1, 0);
    push(0, 1, 'hC1, 1, 0);
    wait_idle(0);
    check_seq("post_rst", 0, 2, 64'hC0C1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
